// File: rtl/mem_pkg.sv
// Shared types and encodings for the data-memory access stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_LOAD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // Effective access width of a store or load; SZ_LOAD marks an illegal load funct3.
    function automatic logic [1:0] access_size(input logic [1:0] store_size,
                                               input logic [2:0] funct3);
        logic [1:0] size;
        if (store_size != SZ_LOAD) begin
            size = store_size;
        end else begin
            case (funct3)
                F3_LB, F3_LBU: size = SZ_BYTE;
                F3_LH, F3_LHU: size = SZ_HALF;
                F3_LW:         size = SZ_WORD;
                default:       size = SZ_LOAD;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a bus word and sign/zero-extends it.
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension according to the load type.
    always_comb begin
        case (off_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            2'd3:    byte_s = word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
        case (funct3_i)
            F3_LB:   result_o = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LBU:  result_o = {{(XLEN-8){1'b0}}, byte_s};
            F3_LH:   result_o = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LHU:  result_o = {{(XLEN-16){1'b0}}, half_s};
            F3_LW:   result_o = word_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory access stage: one load/store per request over a req/ack bus,
// stalling the core until completion, error or ack timeout. Lane logic assumes XLEN=32.
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int XLEN        = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            memory_en,
    input  logic [1:0]      store_size,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata_out,
    output logic            data_valid,
    output logic            mem_stall,
    output logic [1:0]      mem_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    state_e          state_q;
    logic [15:0]     cnt_q;
    logic            is_load_q;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;

    logic [1:0]      size_s;
    logic [1:0]      err_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] wdata_s;
    logic [XLEN-1:0] aligned_s;

    // Decode of the incoming request: width, lane enables, replicated data and errors.
    always_comb begin
        size_s  = access_size(store_size, funct3);
        be_s    = 4'b0000;
        wdata_s = '0;
        case (size_s)
            SZ_BYTE: begin
                be_s    = 4'b0001 << addr[1:0];
                wdata_s = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be_s    = 4'b0011 << addr[1:0];
                wdata_s = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be_s    = 4'b1111;
                wdata_s = wdata;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = '0;
            end
        endcase
        if (store_size == SZ_LOAD) begin
            wdata_s = '0;
        end else begin
            wdata_s = wdata_s;
        end
        if (size_s == SZ_LOAD) begin
            err_s = ERR_ILLEGAL;
        end else if (size_s == SZ_HALF && addr[0]) begin
            err_s = ERR_MISALIGN;
        end else if (size_s == SZ_WORD && addr[1:0] != 2'b00) begin
            err_s = ERR_MISALIGN;
        end else begin
            err_s = ERR_OK;
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .word_i   (bus_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .result_o (aligned_s)
    );

    // Stall follows memory_en while idle so the core freezes in the request cycle itself.
    assign mem_stall = RST_N && ((state_q == REQ) || (state_q == IDLE && memory_en));

    // Access sequencer with registered bus and result outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            is_load_q  <= 1'b0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= 4'b0000;
            bus_wdata  <= '0;
            rdata_out  <= '0;
            data_valid <= 1'b0;
            mem_err    <= ERR_OK;
        end else begin
            data_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (memory_en) begin
                        is_load_q <= (store_size == SZ_LOAD);
                        off_q     <= addr[1:0];
                        f3_q      <= funct3;
                        if (err_s != ERR_OK) begin
                            state_q    <= DONE;
                            mem_err    <= err_s;
                            rdata_out  <= '0;
                            data_valid <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            cnt_q     <= 16'd0;
                            bus_req   <= 1'b1;
                            bus_we    <= (store_size != SZ_LOAD);
                            bus_addr  <= {addr[XLEN-1:2], 2'b00};
                            bus_be    <= be_s;
                            bus_wdata <= wdata_s;
                        end
                    end
                end
                REQ: begin
                    // A late ack still beats the timeout in the same cycle.
                    if (bus_ack) begin
                        state_q    <= DONE;
                        bus_req    <= 1'b0;
                        mem_err    <= ERR_OK;
                        rdata_out  <= is_load_q ? aligned_s : '0;
                        data_valid <= 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q    <= DONE;
                        bus_req    <= 1'b0;
                        mem_err    <= ERR_TIMEOUT;
                        rdata_out  <= '0;
                        data_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed and randomized checks of data_mem_unit against a byte-level reference model.
module tb_data_mem_unit;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        memory_en = 1'b0;
    logic [1:0]  store_size = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata_out;
    logic        data_valid;
    logic        mem_stall;
    logic [1:0]  mem_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    data_mem_unit #(.ACK_TIMEOUT(TO), .XLEN(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .memory_en(memory_en), .store_size(store_size),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata_out(rdata_out),
        .data_valid(data_valid), .mem_stall(mem_stall), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Access width in bytes; 0 means an illegal load type.
    function automatic int nbytes(input logic [1:0] sz, input logic [2:0] f3);
        if (sz != 2'b11) return 1 << sz;
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Issues one access; ack_at = REQ cycle (1-based) carrying bus_ack, 0 = never.
    task automatic run_access(input logic [1:0] sz, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                              input string tag);
        int n, off, e_err, e_req, dv_cyc, stall_cnt, req_cnt, req_idx;
        bit timeout;
        logic [31:0] e_be, e_wd, e_rd, e_addr, v, mask;
        n = nbytes(sz, f3);
        off = int'(a[1:0]);
        e_err = (n == 0) ? 3 : (((off % n) != 0) ? 1 : 0);
        e_be = 32'h0;
        e_wd = 32'h0;
        if (n > 0) begin
            e_be = 32'((((1 << n) - 1) << off) & 15);
            if (sz != 2'b11)
                for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        e_addr = a & 32'hFFFF_FFFC;
        timeout = (ack_at == 0) || (ack_at > TO);
        e_rd = 32'h0;
        if (e_err == 0 && !timeout && sz == 2'b11) begin
            v = rd >> (8 * off);
            mask = (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * n)) - 64'd1);
            v = v & mask;
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
            e_rd = v;
        end
        e_req = (e_err != 0) ? 0 : (timeout ? TO : ack_at);
        if (e_err == 0 && timeout) e_err = 2;

        memory_en = 1'b1; store_size = sz; funct3 = f3; addr = a; wdata = wd;
        dv_cyc = 0; stall_cnt = 0; req_cnt = 0; req_idx = 0;
        for (int c = 1; c <= 20 && dv_cyc == 0; c++) begin
            if (bus_req) begin
                req_idx++;
                bus_ack = (req_idx == ack_at);
                bus_rdata = bus_ack ? rd : $urandom;
                chk({tag, ".bus_addr"}, bus_addr, e_addr);
                chk({tag, ".bus_be"}, 32'(bus_be), e_be);
                chk({tag, ".bus_we"}, 32'(bus_we), 32'(sz != 2'b11));
                if (sz != 2'b11) chk({tag, ".bus_wdata"}, bus_wdata, e_wd);
            end else begin
                bus_ack = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
            @(negedge CLK);
            if (mem_stall) stall_cnt++;
            if (bus_req) req_cnt++;
            if (data_valid) begin
                dv_cyc = c;
                chk({tag, ".mem_err"}, 32'(mem_err), 32'(e_err));
                chk({tag, ".rdata_out"}, rdata_out, e_rd);
            end
            @(posedge CLK); #1;
            memory_en = 1'b0;
        end
        bus_ack = 1'b0;
        chk({tag, ".dv_cycle"}, 32'(dv_cyc), 32'(e_req + 2));
        chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(e_req + 1));
        chk({tag, ".req_cycles"}, 32'(req_cnt), 32'(e_req));
        chk({tag, ".dv_pulse"}, 32'(data_valid), 32'd0);
        chk({tag, ".rdata_hold"}, rdata_out, e_rd);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.bus_req", 32'(bus_req), 32'd0);
        chk("rst.bus_we", 32'(bus_we), 32'd0);
        chk("rst.data_valid", 32'(data_valid), 32'd0);
        chk("rst.mem_stall", 32'(mem_stall), 32'd0);
        chk("rst.bus_addr", bus_addr, 32'd0);
        chk("rst.bus_be", 32'(bus_be), 32'd0);
        chk("rst.bus_wdata", bus_wdata, 32'd0);
        chk("rst.rdata_out", rdata_out, 32'd0);
        chk("rst.mem_err", 32'(mem_err), 32'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        run_access(2'b00, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1, "sb");
        run_access(2'b11, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_F000, 1, "lb");
        run_access(2'b11, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_F000, 1, "lbu");
        run_access(2'b11, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, "lh");
        run_access(2'b11, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, "lhu");
        run_access(2'b11, 3'b010, 32'h0000_2000, 32'h0, 32'h8001_1234, 2, "lw");
        run_access(2'b01, 3'b000, 32'h0000_2006, 32'h0000_BEEF, 32'h0, 3, "sh");
        run_access(2'b10, 3'b000, 32'h0000_3002, 32'h1234_5678, 32'h0, 1, "sw_misalign");
        run_access(2'b11, 3'b011, 32'h0000_3000, 32'h0, 32'hFFFF_FFFF, 1, "ld_illegal");
        run_access(2'b10, 3'b000, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 0, "sw_timeout");
        run_access(2'b11, 3'b010, 32'h0000_4004, 32'h0, 32'h1357_9BDF, 4, "lw_ack_last");
        run_access(2'b11, 3'b001, 32'h0000_4008, 32'h0, 32'h1357_9BDF, 5, "lh_ack_late");

        // Reset while a request is outstanding.
        memory_en = 1'b1; store_size = 2'b10; funct3 = 3'b000;
        addr = 32'h0000_5000; wdata = 32'h0BAD_F00D;
        @(posedge CLK); #1;
        memory_en = 1'b0;
        chk("rreq.bus_req_before", 32'(bus_req), 32'd1);
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        chk("rreq.bus_req", 32'(bus_req), 32'd0);
        chk("rreq.mem_stall", 32'(mem_stall), 32'd0);
        chk("rreq.bus_be", 32'(bus_be), 32'd0);
        #1;
        RST_N = 1'b1;
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rreq.post_bus_req", 32'(bus_req), 32'd0);
            chk("rreq.post_dv", 32'(data_valid), 32'd0);
            chk("rreq.post_stall", 32'(mem_stall), 32'd0);
        end
        @(posedge CLK); #1;
        bus_ack = 1'b0;

        for (int k = 0; k < 40; k++) begin
            run_access(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                       32'($urandom), 32'($urandom), 32'($urandom),
                       int'($urandom_range(0, 6)), "rnd");
            if ($urandom_range(0, 1) == 1) begin
                @(posedge CLK); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Data-memory access stage directly downstream of the instruction controller; consumes its memory_en and store_size outputs plus ALU address and rs2 data.
- Runs one load or store per request over a req/ack data bus.
- Generates byte enables and lane-replicated write data, and sign/zero-extends load data.
- Holds the core with mem_stall until the access completes, errors, or times out.

Parameters:
ACK_TIMEOUT, 255, max cycles in REQ without bus_ack before abort (1..65535)
XLEN, 32, data/address width

Ports:
CLK  in  1  core clock, rising edge
RST_N  in  1  asynchronous active-low reset
memory_en  in  1  current instruction accesses memory
store_size  in  2  00 byte, 01 half, 10 word store; 11 = load
funct3  in  3  load type when store_size=11: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
addr  in  XLEN  byte address from ALU
wdata  in  XLEN  store data (rs2)
rdata_out  out  XLEN  formatted load result, registered
data_valid  out  1  one-cycle pulse in DONE
mem_stall  out  1  core must hold current instruction
mem_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal load funct3; valid with data_valid
bus_req  out  1  transaction request
bus_we  out  1  1 write, 0 read
bus_addr  out  XLEN  word-aligned address, addr[1:0] forced 00
bus_be  out  4  byte enables
bus_wdata  out  XLEN  lane-replicated write data
bus_ack  in  1  slave accepted/completed transaction
bus_rdata  in  XLEN  read data, valid with bus_ack

Behaviour:
- Reset (async, any state): state=IDLE; bus_req, bus_we, data_valid, mem_stall=0; bus_addr, bus_be, bus_wdata, rdata_out=0; mem_err=00; timeout counter=0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - mem_stall = memory_en (combinational).
  - On memory_en=1: capture access type, byte offset, load funct3 and wdata.
  - Check for errors. Misaligned: half with addr[0]=1; word or LW with addr[1:0]!=00. Illegal: load with funct3 in {011,110,111}.
  - Error -> DONE with the error code; no bus transaction.
  - No error -> REQ with bus_req=1 and bus_addr/bus_be/bus_we/bus_wdata registered.
- REQ:
  - mem_stall=1.
  - bus_req and all bus_* outputs stable until bus_ack.
  - bus_ack=1: bus_req drops next cycle. For loads, bus_rdata is captured and formatted. Go to DONE with mem_err=00.
  - Counter increments each REQ cycle without ack. When it reaches ACK_TIMEOUT: drop bus_req, rdata_out=0, mem_err=10, go to DONE.
  - Ack in the same cycle as the timeout wins (ok).
- DONE:
  - mem_stall=0, data_valid=1; rdata_out and mem_err valid.
  - Unconditional return to IDLE.
  - memory_en is ignored in DONE; the core advances this cycle and the next instruction is sampled in IDLE.
- Latency: minimum 3 cycles (IDLE, REQ with same-cycle ack, DONE), with mem_stall high 2 cycles. Error path: 2 cycles, mem_stall high 1 cycle.
- Byte enables:
  - byte: 0001<<off
  - half: 0011<<off
  - word: 1111
- Write data: byte replicated to all 4 lanes; half replicated to both halves; word passthrough.
- Load format (off = captured addr[1:0]):
  - LB/LBU: byte lane off, sign/zero-extended.
  - LH/LHU: halfword at off[1].
  - LW: whole word.
- rdata_out holds its value until the next DONE; stores and errors write 0.
- bus_ack outside REQ: ignored.
- Timeout counter clears on entry to REQ.

Decomposition:
- Shared package mem_pkg holds:
  - state enum {IDLE, REQ, DONE}
  - store_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_LOAD)
  - load funct3 constants
  - mem_err codes
- Sub-module load_align: combinational. Inputs are the bus word, off[1:0] and funct3; output is the extended XLEN result. Instantiated once in the REQ-ack capture path.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000AB. Expect bus_addr=0x1000, bus_be=1000, bus_wdata=0xABABABAB, bus_we=1; with ack in the first REQ cycle, data_valid on cycle 3 and mem_stall high exactly 2 cycles.
- Load LB then LBU: addr=0x2001, bus_rdata=0x0000F000 on ack. Expect rdata_out=0xFFFFFFF0 for LB and 0x000000F0 for LBU; bus_be=0010.
- LH then LHU: addr=0x2002, bus_rdata=0x8001_1234. Expect 0xFFFF8001 and 0x00008001. LW at 0x2000 -> 0x80011234.
- Misaligned word store: addr=0x3002. Expect no bus_req ever, mem_err=01, data_valid in cycle 2, rdata_out=0. Illegal load funct3=011 -> mem_err=11.
- Timeout with ACK_TIMEOUT=4 and bus_ack never asserted: bus_req high 4 cycles then low, mem_err=10, rdata_out=0. Ack arriving in the 4th cycle -> mem_err=00.
- Reset mid-REQ: RST_N low while bus_req=1. Expect bus_req and mem_stall drop without waiting for a clock edge, state=IDLE; an ack after reset release is ignored.
